// File: rtl/mul_seq_ctrl_pkg.sv
// rtl/mul_seq_ctrl_pkg.sv - shared ALU control codes and multiplier FSM state encodings
// Purpose: single home for the ALUCtrl codes decoded by the EX stage and the
//          sequential multiplier state type, so no module carries local literals.
// Ports:   none (package).
package mul_seq_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - one combinational add-and-shift step of the unsigned multiplier
// Purpose: given the current multiplicand, multiplier and accumulator, produce the
//          values for the next iteration.
// Ports:   mcand_i/mplier_i/acc_i  current multiplicand, multiplier, accumulator
//          mcand_o/mplier_o/acc_o  next multiplicand (<<1), multiplier (>>1), accumulator
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0] mplier_o,
    output logic [WIDTH-1:0] acc_o
);

    always_comb begin
        // Accumulate modulo 2^WIDTH: carries out of the top bit are dropped.
        acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequential shift-add multiplier with pipeline stall control
// Purpose: executes a mul instruction in the EX stage over WIDTH iterations,
//          stalling the front of the pipeline until the product is ready.
// Ports:   clk_i, rst_i (async, active-low)
//          start_i, ALUCtrl_i, rs1_data_i, rs2_data_i, flush_i  EX-stage inputs
//          stall_o   freeze PC, IF/ID, ID/EX
//          valid_o   one-cycle pulse with a new product on result_o
//          result_o  low WIDTH bits of the unsigned product
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    mul_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0] step_mplier;
    logic [WIDTH-1:0] step_acc;
    logic             accept;
    logic             last_iter;

    mul_shift_add #(.WIDTH(WIDTH)) u_step (
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_i    (acc_q),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier),
        .acc_o    (step_acc)
    );

    // rst_i gates accept so stall_o is low for the whole reset window.
    assign accept    = rst_i && (state_q == ST_IDLE) && start_i &&
                       (ALUCtrl_i == ALU_MUL) && !flush_i;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mcand_d  = rs1_data_i;
                    mplier_d = rs2_data_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    acc_d    = step_acc;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!flush_i) begin
                    result_d = acc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // The product must be visible in the DONE cycle itself, so result_o bypasses
    // the holding register while valid_o is high; a flush in DONE hides both.
    assign valid_o  = (state_q == ST_DONE) && !flush_i;
    assign result_o = valid_o ? acc_q : result_q;
    assign stall_o  = accept || (state_q == ST_RUN);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl
module tb_mul_seq_ctrl;
    import mul_seq_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_res;
    time         last_valid_t;

    always #5 clk_i = ~clk_i;

    mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .ALUCtrl_i  (ALUCtrl_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic outs(input string tag, input logic s, input logic v, input logic [31:0] r);
        chk({tag, "_stall"},  {31'd0, stall_o}, {31'd0, s});
        chk({tag, "_valid"},  {31'd0, valid_o}, {31'd0, v});
        chk({tag, "_result"}, result_o, r);
    endtask

    function automatic logic [3:0] rand_alu();
        logic [3:0] codes [4];
        codes[0] = ALU_ADD; codes[1] = ALU_SUB; codes[2] = ALU_AND; codes[3] = ALU_OR;
        return codes[$urandom_range(0, 3)];
    endfunction

    // One mul from the accepting cycle (0) to the DONE cycle (33). flush_at/rst_at
    // abort at that absolute cycle; -1 disables. Junk is driven during RUN to
    // show start_i is ignored there.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_p, input int flush_at, input int rst_at);
        for (int c = 0; c <= 33; c++) begin
            @(posedge clk_i); #1;
            if (c == 0) begin
                start_i = 1'b1; ALUCtrl_i = ALU_MUL; flush_i = 1'b0;
                rs1_data_i = a; rs2_data_i = b;
            end else if (c == 33) begin
                start_i = 1'b0; flush_i = (c == flush_at);
            end else begin
                start_i    = 1'($urandom_range(0, 1));
                ALUCtrl_i  = $urandom_range(0, 1) ? ALU_MUL : rand_alu();
                rs1_data_i = $urandom; rs2_data_i = $urandom;
                flush_i    = (c == flush_at);
            end
            if (c == rst_at) begin
                rst_i = 1'b0;
                #1;
                exp_res = 32'd0;
                outs($sformatf("rst_c%0d", c), 1'b0, 1'b0, 32'd0);
                start_i = 1'b0; flush_i = 1'b0;
                @(posedge clk_i); #1;
                outs("rst_hold", 1'b0, 1'b0, 32'd0);
                @(negedge clk_i);
                rst_i = 1'b1;
                return;
            end
            @(negedge clk_i);
            if (c <= 32) begin
                outs($sformatf("run_c%0d", c), 1'b1, 1'b0, exp_res);
            end else if (c == flush_at) begin
                outs("flush_done", 1'b0, 1'b0, exp_res);
            end else begin
                outs("done", 1'b0, 1'b1, exp_p);
                exp_res = exp_p;
                last_valid_t = $time;
            end
            if (c == flush_at) begin
                @(posedge clk_i); #1;
                start_i = 1'b0; flush_i = 1'b0;
                @(negedge clk_i);
                outs($sformatf("after_flush_c%0d", c), 1'b0, 1'b0, exp_res);
                return;
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        time t1;
        logic [31:0] a, b;
        rst_i = 1'b0; start_i = 1'b0; ALUCtrl_i = ALU_ADD; flush_i = 1'b0;
        rs1_data_i = '0; rs2_data_i = '0; exp_res = 32'd0; last_valid_t = 0;

        #1;
        outs("reset", 1'b0, 1'b0, 32'd0);
        start_i = 1'b1; ALUCtrl_i = ALU_MUL;
        #1;
        outs("reset_start", 1'b0, 1'b0, 32'd0);
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        run_mul(32'd3, 32'd5, 32'h0000000F, -1, -1);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, -1, -1);
        run_mul(32'h80000000, 32'd2, 32'h00000000, -1, -1);
        run_mul(32'd1234, 32'd1000, 32'd1234000, -1, -1);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            start_i = 1'b1; ALUCtrl_i = rand_alu(); flush_i = 1'($urandom_range(0, 1));
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            @(negedge clk_i);
            outs($sformatf("nonmul_%0d", i), 1'b0, 1'b0, exp_res);
        end

        @(posedge clk_i); #1;
        start_i = 1'b1; ALUCtrl_i = ALU_MUL; flush_i = 1'b1;
        @(negedge clk_i);
        outs("idle_flush_start", 1'b0, 1'b0, exp_res);
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        outs("idle_flush_after", 1'b0, 1'b0, exp_res);

        a = $urandom; b = $urandom;
        run_mul(a, b, ref_mul(a, b), 10, -1);
        run_mul(32'd7, 32'd6, 32'h0000002A, -1, -1);

        a = $urandom; b = $urandom;
        run_mul(a, b, ref_mul(a, b), -1, 15);
        run_mul(32'd2, 32'd9, 32'h00000012, -1, -1);

        a = $urandom; b = $urandom;
        run_mul(a, b, ref_mul(a, b), -1, -1);
        t1 = last_valid_t;
        a = $urandom; b = $urandom;
        run_mul(a, b, ref_mul(a, b), -1, -1);
        chk("b2b_gap", 32'(last_valid_t - t1), 32'd340);

        a = $urandom; b = $urandom;
        run_mul(a, b, ref_mul(a, b), 33, -1);

        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom_range(0, 3) == 0 ? 32'(i) : $urandom;
            run_mul(a, b, ref_mul(a, b), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CNT_W, default 6: iteration-counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  EX stage holds a valid R-type instruction this cycle.
REQ-006 ALUCtrl_i  input  4  ALU control code from the ALU control decoder; 4'b0111 = mul.
REQ-007 rs1_data_i  input  WIDTH  multiplicand.
REQ-008 rs2_data_i  input  WIDTH  multiplier.
REQ-009 flush_i  input  1  pipeline flush; aborts any operation in progress.
REQ-010 stall_o  output  1  freezes the PC, IF/ID and ID/EX registers while high.
REQ-011 valid_o  output  1  one-cycle pulse; result_o holds a new product.
REQ-012 result_o  output  WIDTH  low WIDTH bits of the unsigned product.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 In IDLE, a start is accepted when start_i=1, ALUCtrl_i=4'b0111 and flush_i=0.
- Accept: latch rs1/rs2 into the multiplicand/multiplier registers, clear the accumulator, clear the counter, go to RUN.
REQ-015 In IDLE, start_i with any other ALUCtrl_i SHALL be ignored, and stall_o SHALL stay 0.
REQ-016 In RUN, each cycle:
- If multiplier[0]=1, add the multiplicand to the accumulator, modulo 2^WIDTH.
- Shift the multiplicand left by 1 and the multiplier right by 1.
- Increment the counter.
REQ-017 RUN SHALL go to DONE on the cycle in which the counter reaches WIDTH-1; RUN therefore lasts exactly WIDTH cycles, with no early termination.
REQ-018 In DONE:
- Load the accumulator into result_o.
- Assert valid_o for exactly one cycle.
- Return to IDLE on the next edge.
REQ-019 stall_o SHALL be combinational: 1 when (IDLE and start accepted) or state=RUN; otherwise 0, including in DONE.
REQ-020 Latency: start accepted in cycle 0; stall_o high in cycles 0..WIDTH; valid_o high in cycle WIDTH+1, when the pipeline advances.
REQ-021 result_o SHALL hold its value until the next DONE; it SHALL NOT change on an abort.
REQ-022 flush_i=1 in RUN or DONE:
- Go to IDLE on the next edge.
- Suppress valid_o in that cycle.
- Leave result_o unchanged.
- Drive stall_o low from the next cycle.
REQ-023 start_i SHALL be ignored in RUN and DONE; flush_i takes priority over start_i in IDLE.
REQ-024 Back-to-back mul instructions: a start in the cycle after DONE (IDLE) SHALL be accepted normally.

Reset
REQ-025 While rst_i=0, asynchronously:
- state=IDLE; counter, accumulator and operand registers=0.
- result_o=0, valid_o=0, stall_o=0.
REQ-026 A reset asserted mid-RUN SHALL abandon the operation with no valid_o pulse; after release, the block SHALL accept a new start normally.

Structure
REQ-027 ALUCtrl codes (add 0010, sub 0110, and 0000, or 0001, mul 0111) and the FSM state encodings SHALL reside in the shared ALU definitions include file; no local literals.
REQ-028 One sub-module, mul_shift_add, SHALL hold the combinational add-and-shift step; mul_seq_ctrl SHALL own the FSM, counter and registers.

Verification
REQ-029 The bench SHALL cover these directed scenarios (WIDTH=32):
- 3 x 5 with start in cycle 0 -> stall_o high cycles 0..32; valid_o=1 and result_o=0x0000000F in cycle 33.
- 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000001; 0x80000000 x 2 -> result_o=0x00000000 (wrap-around).
- start_i with ALUCtrl_i=0010 -> stall_o=0 and valid_o=0 throughout; result_o unchanged.
- flush_i in cycle 10 of RUN -> stall_o=0 from cycle 11, no valid_o, result_o keeps its prior value; a new 7 x 6 start then yields 0x0000002A.
- rst_i low in cycle 15 of RUN -> all outputs 0 immediately; after release, 2 x 9 -> 0x00000012 with normal latency.
- Two mul instructions back-to-back -> two valid_o pulses 34 cycles apart, correct products.
